feeding_drive_controller: RTL and testbench
===========================================

Name: feeding_drive_controller

Overview:
- Behavioural responder that closes the loop around the nourishment subsystem.
- Consumes the `hungry`/`starving` drive flags and the food stimulus bit, and produces the eat/seek/cry action bits that feed back into the action bus.
- Sequential Moore FSM with a shared duration counter: seek, eat for a fixed meal length, then a digestion refractory period.
- Sits between the nourishment system outputs and the top-level action arbiter.

Parameters:
- FOOD_BIT, 0: index in `stimuli` meaning "food present".
- EAT_BIT, 0: index in `action` driven while eating.
- SEEK_BIT, 1: index in `action` driven while seeking.
- CRY_BIT, 2: index in `action` driven on seek timeout while starving.
- CNT_W, 8: width of the duration counter.
- EAT_CYCLES, 16: cycles of continuous eating that make one meal (1..2^CNT_W-1).
- DIGEST_CYCLES, 64: refractory cycles after a meal (1..2^CNT_W-1).
- SEEK_TIMEOUT, 200: seek cycles before a cry is allowed (1..2^CNT_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- hungry  input  1  nourishment level low.
- starving  input  1  nourishment level critical.
- stimuli  input  16  stimulus bus; only stimuli[FOOD_BIT] is used.
- action  output  8  action bits; only EAT_BIT, SEEK_BIT and CRY_BIT are ever set, all other bits are 0.
- drive_state  output  2  current state: 0 IDLE, 1 SEEK, 2 EAT, 3 DIGEST.
- meals  output  8  completed-meal count, saturating at 255.

Behaviour:
- All state is registered on the rising edge of clk. `rst`=1 at an edge gives:
  - state IDLE, counter 0, cry flag 0, meals 0;
  - `action`=0 and `drive_state`=0 from the following cycle.
- Reset mid-operation aborts any state immediately; no meal is counted.
- `action` and `drive_state` are decoded from registered state only; there is no combinational path from inputs to outputs.
  - action[SEEK_BIT]=1 iff state==SEEK.
  - action[EAT_BIT]=1 iff state==EAT.
  - action[CRY_BIT]=cry flag, which can only be 1 in SEEK.
- IDLE:
  - hungry=1 → SEEK next cycle, counter cleared. Otherwise stay in IDLE.
  - Food alone does not trigger eating.
- SEEK, priority order:
  1. hungry=0 → IDLE, cry cleared.
  2. Food=1 → EAT, counter cleared, cry cleared.
  3. Otherwise, counter increments and saturates at SEEK_TIMEOUT.
- Cry flag in SEEK:
  - Set when counter==SEEK_TIMEOUT and starving=1.
  - Cleared when starving=0.
  - First cry cycle is SEEK_TIMEOUT+1 cycles after SEEK entry.
- EAT:
  - Counter increments each cycle with food=1.
  - On the cycle the counter equals EAT_CYCLES-1 with food=1 → DIGEST, meals+1 (saturating), counter cleared. EAT therefore lasts exactly EAT_CYCLES cycles.
  - Food=0 before completion aborts with no meal counted: → SEEK if hungry=1, else → IDLE. Counter is cleared either way.
  - hungry dropping during EAT does not abort; the meal completes.
  - Food dropping on the completing cycle counts as abort, because completion requires food=1 on that cycle.
- DIGEST:
  - Lasts exactly DIGEST_CYCLES cycles, then → IDLE.
  - Ignores hungry, starving and food.
  - `action`=0 throughout.
- If hungry=1 on return to IDLE, SEEK is entered on the next cycle; there is one IDLE cycle minimum.
- `meals` holds at 255. No arithmetic wraps: the counter saturates in SEEK and is bounded by the terminal counts in EAT and DIGEST.

Test Plan:
- Reset with hungry=1 and food=1 → action=0, drive_state=0, meals=0. One cycle after reset release, drive_state=1 and action=0x02.
- SEEK with food raised at cycle 5 → drive_state=2 next cycle. action=0x01 for exactly 16 cycles, then drive_state=3 and meals=1. action=0 for 64 cycles, then drive_state=0.
- Food dropped after 10 EAT cycles with hungry=1 → SEEK next cycle, meals unchanged. Same case with hungry=0 → IDLE.
- hungry=1, starving=1, no food → action=0x02 for 201 cycles, then 0x06. Dropping starving → 0x02 next cycle. Dropping hungry → 0x00 and IDLE.
- In SEEK, hungry falls and food rises in the same cycle → IDLE, no EAT. In EAT, hungry dropped mid-meal → meal completes, meals+1.
- 256 forced back-to-back meals → meals saturates at 255. Assert rst during EAT → IDLE next cycle, meals=0, action=0.

Source files
------------

// File: rtl/feeding_drive_controller.sv
// rtl/feeding_drive_controller.sv - seek/eat/digest drive FSM with shared duration counter
module feeding_drive_controller #(
    parameter int FOOD_BIT      = 0,
    parameter int EAT_BIT       = 0,
    parameter int SEEK_BIT      = 1,
    parameter int CRY_BIT       = 2,
    parameter int CNT_W         = 8,
    parameter int EAT_CYCLES    = 16,
    parameter int DIGEST_CYCLES = 64,
    parameter int SEEK_TIMEOUT  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hungry,
    input  logic        starving,
    input  logic [15:0] stimuli,
    output logic [7:0]  action,
    output logic [1:0]  drive_state,
    output logic [7:0]  meals
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_EAT    = 2'd2,
        ST_DIGEST = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SEEK_TERM   = CNT_W'(SEEK_TIMEOUT);
    localparam logic [CNT_W-1:0] EAT_TERM    = CNT_W'(EAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGEST_TERM = CNT_W'(DIGEST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cry_q, cry_d;
    logic [7:0]       meals_q, meals_d;
    logic             food;
    logic             stim_unused;

    assign food        = stimuli[FOOD_BIT];
    assign stim_unused = ^stimuli;

    // Cry is only ever computed in the SEEK-hold branch, so every exit from SEEK drops it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cry_d   = 1'b0;
        meals_d = meals_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (hungry) begin
                    state_d = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (!hungry) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (food) begin
                    state_d = ST_EAT;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != SEEK_TERM) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    cry_d = starving && (cnt_q == SEEK_TERM);
                end
            end
            ST_EAT: begin
                if (!food) begin
                    state_d = hungry ? ST_SEEK : ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == EAT_TERM) begin
                    state_d = ST_DIGEST;
                    cnt_d   = '0;
                    if (meals_q != 8'hFF) begin
                        meals_d = meals_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DIGEST: begin
                if (cnt_q == DIGEST_TERM) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cry_q   <= 1'b0;
            meals_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cry_q   <= cry_d;
            meals_q <= meals_d;
        end
    end

    always_comb begin
        action           = 8'h00;
        action[SEEK_BIT] = (state_q == ST_SEEK);
        action[EAT_BIT]  = (state_q == ST_EAT);
        action[CRY_BIT]  = cry_q;
    end

    assign drive_state = state_q;
    assign meals       = meals_q;

endmodule

// File: tb/tb_feeding_drive_controller.sv
// tb/tb_feeding_drive_controller.sv - directed bench with behavioural drive model
module tb_feeding_drive_controller;

    localparam int EAT_CYCLES    = 16;
    localparam int DIGEST_CYCLES = 64;
    localparam int SEEK_TIMEOUT  = 200;

    logic        clk;
    logic        rst;
    logic        hungry;
    logic        starving;
    logic [15:0] stimuli;
    logic [7:0]  action;
    logic [1:0]  drive_state;
    logic [7:0]  meals;

    int n_run;
    int n_fail;

    feeding_drive_controller #(
        .FOOD_BIT(0), .EAT_BIT(0), .SEEK_BIT(1), .CRY_BIT(2), .CNT_W(8),
        .EAT_CYCLES(EAT_CYCLES), .DIGEST_CYCLES(DIGEST_CYCLES), .SEEK_TIMEOUT(SEEK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hungry(hungry),
        .starving(starving),
        .stimuli(stimuli),
        .action(action),
        .drive_state(drive_state),
        .meals(meals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: state 0 idle, 1 seek, 2 eat, 3 digest; age = cycles spent in current state.
    int m_state;
    int m_age;
    int m_meals;
    bit m_cry;
    bit m_valid;

    initial begin
        m_state = 0;
        m_age   = 0;
        m_meals = 0;
        m_cry   = 1'b0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_age   <= 0;
            m_meals <= 0;
            m_cry   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_state)
                0: if (hungry) begin
                    m_state <= 1;
                    m_age   <= 0;
                end
                1: if (!hungry) begin
                    m_state <= 0;
                    m_cry   <= 1'b0;
                end else if (stimuli[0]) begin
                    m_state <= 2;
                    m_age   <= 0;
                    m_cry   <= 1'b0;
                end else begin
                    m_cry <= starving && (m_age >= SEEK_TIMEOUT);
                    m_age <= m_age + 1;
                end
                2: if (!stimuli[0]) begin
                    m_state <= hungry ? 1 : 0;
                    m_age   <= 0;
                end else if (m_age == EAT_CYCLES - 1) begin
                    m_state <= 3;
                    m_age   <= 0;
                    m_meals <= (m_meals >= 255) ? 255 : m_meals + 1;
                end else begin
                    m_age <= m_age + 1;
                end
                default: if (m_age == DIGEST_CYCLES - 1) begin
                    m_state <= 0;
                    m_age   <= 0;
                end else begin
                    m_age <= m_age + 1;
                end
            endcase
        end
    end

    function automatic logic [7:0] model_action(input int st, input bit cry);
        logic [7:0] a;
        a = 8'h00;
        if (st == 1) a = a | 8'h02;
        if (st == 2) a = a | 8'h01;
        if (cry)     a = a | 8'h04;
        return a;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_run = n_run + 3;
                if (action !== model_action(m_state, m_cry)) begin
                    n_fail++;
                    $display("FAIL model_action t=%0t: got %02h expected %02h", $time, action, model_action(m_state, m_cry));
                end
                if (drive_state !== 2'(m_state)) begin
                    n_fail++;
                    $display("FAIL model_state t=%0t: got %0d expected %0d", $time, drive_state, m_state);
                end
                if (meals !== 8'(m_meals)) begin
                    n_fail++;
                    $display("FAIL model_meals t=%0t: got %0d expected %0d", $time, meals, m_meals);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_food(input logic f);
        stimuli = {15'h5A5A, f};
    endtask

    int n;

    initial begin
        n_run    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        hungry   = 1'b1;
        starving = 1'b0;
        set_food(1'b1);
        tick(2);
        chk("reset_action", int'(action), 0);
        chk("reset_state", int'(drive_state), 0);
        chk("reset_meals", int'(meals), 0);

        rst = 1'b0;
        tick(1);
        chk("release_state", int'(drive_state), 1);
        chk("release_action", int'(action), 2);
        set_food(1'b0);

        tick(4);
        set_food(1'b1);
        tick(1);
        chk("eat_entry", int'(drive_state), 2);
        n = 0;
        while (action == 8'h01 && n < 100) begin
            n++;
            tick(1);
        end
        chk("eat_len", n, 16);
        chk("digest_entry", int'(drive_state), 3);
        chk("meal_one", int'(meals), 1);
        n = 0;
        while (drive_state == 2'd3 && action == 8'h00 && n < 200) begin
            n++;
            tick(1);
        end
        chk("digest_len", n, 64);
        chk("digest_exit", int'(drive_state), 0);
        tick(1);
        chk("reseek", int'(drive_state), 1);

        tick(1);
        tick(9);
        set_food(1'b0);
        tick(1);
        chk("abort_seek", int'(drive_state), 1);
        chk("abort_meals", int'(meals), 1);
        set_food(1'b1);
        tick(1);
        tick(9);
        set_food(1'b0);
        hungry = 1'b0;
        tick(1);
        chk("abort_idle", int'(drive_state), 0);
        chk("abort_idle_meals", int'(meals), 1);

        hungry   = 1'b1;
        starving = 1'b1;
        tick(1);
        n = 0;
        while (action == 8'h02 && n < 300) begin
            n++;
            tick(1);
        end
        chk("seek_before_cry", n, 201);
        chk("cry_on", int'(action), 6);
        starving = 1'b0;
        tick(1);
        chk("cry_off", int'(action), 2);
        starving = 1'b1;
        tick(1);
        chk("cry_again", int'(action), 6);
        hungry = 1'b0;
        tick(1);
        chk("cry_idle_action", int'(action), 0);
        chk("cry_idle_state", int'(drive_state), 0);
        starving = 1'b0;

        hungry = 1'b1;
        tick(1);
        hungry = 1'b0;
        set_food(1'b1);
        tick(1);
        chk("sated_beats_food", int'(drive_state), 0);
        tick(1);
        chk("food_alone", int'(drive_state), 0);
        hungry = 1'b1;
        set_food(1'b0);
        tick(1);
        set_food(1'b1);
        tick(1);
        chk("eat2_entry", int'(drive_state), 2);
        hungry = 1'b0;
        tick(16);
        chk("sated_meal_done", int'(drive_state), 3);
        chk("sated_meal_count", int'(meals), 2);
        tick(64);
        chk("sated_idle", int'(drive_state), 0);

        hungry = 1'b1;
        tick(256 * 82);
        chk("meals_saturate", int'(meals), 255);

        n = 0;
        while (drive_state != 2'd2 && n < 100) begin
            n++;
            tick(1);
        end
        chk("find_eat", int'(drive_state), 2);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rst_eat_state", int'(drive_state), 0);
        chk("rst_eat_action", int'(action), 0);
        chk("rst_eat_meals", int'(meals), 0);
        rst    = 1'b0;
        hungry = 1'b0;
        tick(2);
        chk("post_rst_idle", int'(drive_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
